// File: rtl/tick_bcd_timer.sv
// Synchronises the divided slow clock, turns each rising edge into a one-cycle
// tick, and counts ticks in a DIGITS-digit BCD run/pause/done timer.
module tick_bcd_timer #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  basys_clk,
  input  logic                  rst_n,
  input  logic                  slow_clk,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   limit_bcd,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  running,
  output logic                  tick,
  output logic                  done,
  output logic                  wrapped
);

  localparam int unsigned CW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_c;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          inc_c;
  logic                   inc_carry_c;
  logic                   limit_ok_c;
  logic                   carry;
  logic                   tick_q;
  logic                   done_q, done_d;
  logic                   wrapped_q, wrapped_d;
  logic                   running_q;

  // Synchroniser chain plus previous-level flop for rising-edge detection
  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
      tick_q <= edge_c;
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // BCD increment with ripple carry; limit is usable only if nonzero and all nibbles are decimal
  always_comb begin
    inc_c      = count_q;
    carry      = 1'b1;
    limit_ok_c = |limit_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (limit_bcd[4*i +: 4] > 4'd9) limit_ok_c = 1'b0;
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_c[4*i +: 4] = 4'd0;
        end else begin
          inc_c[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    inc_carry_c = carry;
  end

  // Next-state logic, command priority clear > stop > start
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    wrapped_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
      if (state_q == DONE) count_d = '0;
    end else if ((state_q == RUN) && edge_c) begin
      count_d = inc_c;
      if (limit_ok_c && (inc_c == limit_bcd)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if (!limit_ok_c && inc_carry_c) begin
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
      running_q <= (state_d == RUN);
    end
  end

  assign count_bcd = count_q;
  assign running   = running_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Bench for tick_bcd_timer: directed scenarios plus random commands checked
// against a decimal-integer model of the timer.
module tb_tick_bcd_timer;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CW          = 4 * DIGITS;
  localparam int          MOD         = 10000;

  logic          clk = 1'b0;
  logic          rst_n, slow_clk, start, stop, clear;
  logic [CW-1:0] limit_bcd, count_bcd;
  logic          running, tick, done, wrapped;

  int n_cmp  = 0;
  int n_fail = 0;

  // model: state 0 idle, 1 run, 2 pause, 3 done; count held as a plain integer
  int m_state, m_count;
  bit m_tick, m_done, m_wrapped;
  bit hist [SYNC_STAGES+1];
  int obs_done, obs_wrap, obs_tick;

  tick_bcd_timer #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .basys_clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start(start),
    .stop(stop), .clear(clear), .limit_bcd(limit_bcd), .count_bcd(count_bcd),
    .running(running), .tick(tick), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // decimal value of the limit, 0 meaning free-run
  function automatic int lim_val(input logic [CW-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return 0;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_tick = 0; m_done = 0; m_wrapped = 0;
    for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 1'b0;
  endtask

  // advance model and DUT by one clock using the inputs currently driven
  task automatic step();
    bit e;
    int lim;
    e = hist[SYNC_STAGES-1] & ~hist[SYNC_STAGES];
    lim = lim_val(limit_bcd);
    m_tick = e; m_done = 0; m_wrapped = 0;
    if (clear) begin
      m_state = 0; m_count = 0;
    end else if (stop) begin
      if (m_state == 1) m_state = 2;
    end else if (start && m_state != 1) begin
      if (m_state == 3) m_count = 0;
      m_state = 1;
    end else if (m_state == 1 && e) begin
      m_count = (m_count + 1) % MOD;
      if (lim != 0 && m_count == lim) begin
        m_state = 3; m_done = 1;
      end else if (lim == 0 && m_count == 0) begin
        m_wrapped = 1;
      end
    end
    for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = slow_clk;
    @(posedge clk); #1;
    start = 0; stop = 0; clear = 0;
    obs_done += int'(done);
    obs_wrap += int'(wrapped);
    obs_tick += int'(tick);
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      slow_clk = 1'b1; step();
      slow_clk = 1'b0; step();
    end
  endtask

  task automatic flush();
    slow_clk = 1'b0;
    repeat (SYNC_STAGES + 1) step();
  endtask

  task automatic test_reset();
    n_cmp++; if (count_bcd !== '0) begin n_fail++; $display("FAIL rst_count: got %h want 0000", count_bcd); end
    n_cmp++; if ({running, tick, done, wrapped} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {running, tick, done, wrapped}); end
    clear = 1; step();
    start = 1; step();
    edges(42); flush();
    n_cmp++; if (count_bcd !== 16'h0042) begin n_fail++; $display("FAIL pre_rst_count: got %h want 0042", count_bcd); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (count_bcd !== '0) begin n_fail++; $display("FAIL async_rst_count: got %h want 0000", count_bcd); end
    n_cmp++; if ({running, tick, done, wrapped} !== 4'b0) begin n_fail++; $display("FAIL async_rst_flags: got %b want 0000", {running, tick, done, wrapped}); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    obs_tick = 0;
    slow_clk = 1'b1;
    repeat (SYNC_STAGES + 2) step();
    flush();
    n_cmp++; if (obs_tick !== 1) begin n_fail++; $display("FAIL post_rst_tick: got %0d pulses want 1", obs_tick); end
    n_cmp++; if (count_bcd !== '0 || running !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got %h/%b want 0000/0", count_bcd, running); end
  endtask

  task automatic test_latency();
    limit_bcd = '0;
    clear = 1; step();
    start = 1; step();
    flush();
    slow_clk = 1'b1; step();
    n_cmp++; if (tick !== 1'b0 || count_bcd !== 16'h0000) begin n_fail++; $display("FAIL lat_k: got %b/%h want 0/0000", tick, count_bcd); end
    repeat (SYNC_STAGES - 1) step();
    n_cmp++; if (tick !== 1'b0 || count_bcd !== 16'h0000) begin n_fail++; $display("FAIL lat_pre: got %b/%h want 0/0000", tick, count_bcd); end
    step();
    n_cmp++; if (tick !== 1'b1 || count_bcd !== 16'h0001) begin n_fail++; $display("FAIL lat_edge: got %b/%h want 1/0001", tick, count_bcd); end
    slow_clk = 1'b0; step();
    n_cmp++; if (tick !== 1'b0 || count_bcd !== 16'h0001) begin n_fail++; $display("FAIL lat_post: got %b/%h want 0/0001", tick, count_bcd); end
    flush();
  endtask

  task automatic test_carry();
    limit_bcd = '0;
    clear = 1; step();
    start = 1; step();
    edges(9); flush();
    n_cmp++; if (count_bcd !== 16'h0009) begin n_fail++; $display("FAIL carry_9: got %h want 0009", count_bcd); end
    edges(1); flush();
    n_cmp++; if (count_bcd !== 16'h0010) begin n_fail++; $display("FAIL carry_10: got %h want 0010", count_bcd); end
    edges(989); flush();
    n_cmp++; if (count_bcd !== 16'h0999) begin n_fail++; $display("FAIL carry_999: got %h want 0999", count_bcd); end
    edges(1); flush();
    n_cmp++; if (count_bcd !== 16'h1000) begin n_fail++; $display("FAIL carry_1000: got %h want 1000", count_bcd); end
    obs_wrap = 0;
    edges(8999); flush();
    n_cmp++; if (count_bcd !== 16'h9999 || obs_wrap !== 0) begin n_fail++; $display("FAIL carry_9999: got %h wraps %0d want 9999 wraps 0", count_bcd, obs_wrap); end
    edges(1); flush();
    n_cmp++; if (count_bcd !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h want 0000", count_bcd); end
    n_cmp++; if (obs_wrap !== 1) begin n_fail++; $display("FAIL wrap_pulse: got %0d cycles want 1", obs_wrap); end
  endtask

  task automatic test_limit();
    limit_bcd = 16'h0005;
    clear = 1; step();
    start = 1; step();
    obs_done = 0;
    edges(5); flush();
    n_cmp++; if (count_bcd !== 16'h0005) begin n_fail++; $display("FAIL limit_count: got %h want 0005", count_bcd); end
    n_cmp++; if (obs_done !== 1 || running !== 1'b0) begin n_fail++; $display("FAIL limit_done: got %0d pulses run %b want 1 run 0", obs_done, running); end
    edges(3); flush();
    n_cmp++; if (count_bcd !== 16'h0005 || obs_done !== 1) begin n_fail++; $display("FAIL limit_hold: got %h/%0d want 0005/1", count_bcd, obs_done); end
    start = 1; step();
    n_cmp++; if (count_bcd !== 16'h0000 || running !== 1'b1) begin n_fail++; $display("FAIL limit_restart: got %h/%b want 0000/1", count_bcd, running); end
  endtask

  task automatic test_pause();
    limit_bcd = '0;
    clear = 1; step();
    start = 1; step();
    edges(3); flush();
    slow_clk = 1'b1; step();
    slow_clk = 1'b0;
    repeat (SYNC_STAGES - 1) step();
    stop = 1; step();
    n_cmp++; if (count_bcd !== 16'h0003 || running !== 1'b0) begin n_fail++; $display("FAIL pause_stop_edge: got %h/%b want 0003/0", count_bcd, running); end
    edges(2); flush();
    n_cmp++; if (count_bcd !== 16'h0003) begin n_fail++; $display("FAIL pause_hold: got %h want 0003", count_bcd); end
    start = 1; step();
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL pause_resume: got %b want 1", running); end
    edges(1); flush();
    n_cmp++; if (count_bcd !== 16'h0004) begin n_fail++; $display("FAIL pause_next: got %h want 0004", count_bcd); end
  endtask

  task automatic test_priority();
    limit_bcd = '0;
    clear = 1; step();
    start = 1; step();
    edges(7); flush();
    clear = 1; stop = 1; start = 1; step();
    n_cmp++; if (count_bcd !== 16'h0000 || running !== 1'b0) begin n_fail++; $display("FAIL prio_clear: got %h/%b want 0000/0", count_bcd, running); end
    limit_bcd = 16'h00A3;
    start = 1; step();
    obs_done = 0;
    edges(5); flush();
    n_cmp++; if (count_bcd !== 16'h0005 || running !== 1'b1 || obs_done !== 0) begin n_fail++; $display("FAIL bad_limit: got %h/%b/%0d want 0005/1/0", count_bcd, running, obs_done); end
  endtask

  task automatic test_random();
    logic [CW-1:0] lims [5];
    int r;
    lims[0] = 16'h0000; lims[1] = 16'h0005; lims[2] = 16'h0012;
    lims[3] = 16'h00A3; lims[4] = 16'h0003;
    limit_bcd = 16'h0012;
    for (int c = 0; c < 800; c++) begin
      slow_clk = 1'($urandom % 2);
      r = int'($urandom % 100);
      start = (r < 12);
      stop  = (r >= 12 && r < 16);
      clear = (r == 16);
      if ($urandom % 60 == 0) limit_bcd = lims[$urandom % 5];
      step();
      n_cmp++; if (count_bcd !== to_bcd(m_count)) begin n_fail++; $display("FAIL rnd_count c%0d: got %h want %h", c, count_bcd, to_bcd(m_count)); end
      n_cmp++; if (running !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_running c%0d: got %b want %b", c, running, m_state == 1); end
      n_cmp++; if (tick !== m_tick) begin n_fail++; $display("FAIL rnd_tick c%0d: got %b want %b", c, tick, m_tick); end
      n_cmp++; if (done !== m_done || wrapped !== m_wrapped) begin n_fail++; $display("FAIL rnd_pulses c%0d: got %b%b want %b%b", c, done, wrapped, m_done, m_wrapped); end
    end
    flush();
  endtask

  initial begin
    rst_n = 1'b0; slow_clk = 1'b0; start = 0; stop = 0; clear = 0;
    limit_bcd = '0;
    obs_done = 0; obs_wrap = 0; obs_tick = 0;
    model_reset();
    #12;
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_latency();
    test_carry();
    test_limit();
    test_pause();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
